// File: rtl/fft_stage_seq.sv
// fft_stage_seq: in-place radix-2 DIT FFT sequencer; start_i->busy_o/done_o, stage_o, bf_vld_o/bf_rdy_i command with addr_a_o/addr_b_o/tw_addr_o/bf_last_o
module fft_stage_seq #(
  parameter int N = 16,
  parameter int BF_LAT = 3
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [$clog2($clog2(N))-1:0] stage_o,
  output logic                      bf_vld_o,
  input  logic                      bf_rdy_i,
  output logic [$clog2(N)-1:0]      addr_a_o,
  output logic [$clog2(N)-1:0]      addr_b_o,
  output logic [$clog2(N)-2:0]      tw_addr_o,
  output logic                      bf_last_o
);
  localparam int L = $clog2(N);
  localparam int AW = L;
  localparam int KW = L - 1;
  localparam int SW = $clog2(L);
  localparam int CW = BF_LAT > 1 ? $clog2(BF_LAT) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic fin, last_s;
  logic [KW-1:0] pos, grp;
  logic [AW-1:0] a;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      s_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    k_d = k_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    fin = 1'b0;
    last_s = s_q == SW'(L - 1);
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        s_d = '0;
        k_d = '0;
      end
      RUN: if (bf_rdy_i) begin
        k_d = k_q + KW'(1);
        if (&k_q) begin
          state_d = DRAIN;
          cnt_d = '0;
          fin = BF_LAT == 0;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        fin = cnt_q == CW'(BF_LAT - 1);
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = last_s ? IDLE : RUN;
      s_d = last_s ? '0 : s_q + SW'(1);
      done_d = last_s;
    end
  end
  assign busy_o = state_q != IDLE;
  assign bf_vld_o = state_q == RUN;
  assign done_o = done_q;
  assign stage_o = s_q;
  always_comb begin
    pos = k_q & ((KW'(1) << s_q) - KW'(1));
    grp = k_q >> s_q;
    a = ({grp, 1'b0} << s_q) | AW'(pos);
    addr_a_o = bf_vld_o ? a : '0;
    addr_b_o = bf_vld_o ? a + (AW'(1) << s_q) : '0;
    tw_addr_o = bf_vld_o ? pos << (SW'(L - 1) - s_q) : '0;
    bf_last_o = bf_vld_o && (&k_q);
  end
endmodule

// File: tb/tb_fft_stage_seq.sv
// tb_fft_stage_seq: scoreboard bench for fft_stage_seq in three configurations
module tb_fft_stage_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic a_rstn = 1'b0, a_start = 1'b0, a_rdy = 1'b1;
  logic a_busy, a_done, a_vld, a_last;
  logic [1:0] a_stage, a_tw;
  logic [2:0] a_aa, a_ab;
  logic b_rstn = 1'b0, b_start = 1'b0, b_rdy = 1'b1;
  logic b_busy, b_done, b_vld, b_last;
  logic [1:0] b_stage;
  logic [2:0] b_tw;
  logic [3:0] b_aa, b_ab;
  logic c_rstn = 1'b0, c_start = 1'b1, c_rdy = 1'b1;
  logic c_busy, c_done, c_vld, c_last;
  logic [1:0] c_stage, c_tw;
  logic [2:0] c_aa, c_ab;
  fft_stage_seq #(.N(8), .BF_LAT(2)) u_a (
    .clk_i(clk), .rstn_i(a_rstn), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
    .stage_o(a_stage), .bf_vld_o(a_vld), .bf_rdy_i(a_rdy), .addr_a_o(a_aa), .addr_b_o(a_ab),
    .tw_addr_o(a_tw), .bf_last_o(a_last));
  fft_stage_seq #(.N(16), .BF_LAT(0)) u_b (
    .clk_i(clk), .rstn_i(b_rstn), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .stage_o(b_stage), .bf_vld_o(b_vld), .bf_rdy_i(b_rdy), .addr_a_o(b_aa), .addr_b_o(b_ab),
    .tw_addr_o(b_tw), .bf_last_o(b_last));
  fft_stage_seq #(.N(8), .BF_LAT(1)) u_c (
    .clk_i(clk), .rstn_i(c_rstn), .start_i(c_start), .busy_o(c_busy), .done_o(c_done),
    .stage_o(c_stage), .bf_vld_o(c_vld), .bf_rdy_i(c_rdy), .addr_a_o(c_aa), .addr_b_o(c_ab),
    .tw_addr_o(c_tw), .bf_last_o(c_last));
  int qa[$], qb[$], qc[$];
  int tab8 [12][3] = '{'{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0},
                       '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
                       '{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3}};
  function automatic int enc(input int s, input int a, input int b, input int tw, input int last);
    return (s << 24) | (a << 16) | (b << 8) | (tw << 1) | last;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic push8(input int which);
    for (int i = 0; i < 12; i++) begin
      int v;
      v = enc(i / 4, tab8[i][0], tab8[i][1], tab8[i][2], (i % 4 == 3) ? 1 : 0);
      if (which == 0) qa.push_back(v);
      else qc.push_back(v);
    end
  endtask
  task automatic pushb();
    int kk;
    kk = 0;
    for (int s = 0; s < 4; s++)
      for (int g = 0; g < (8 >> s); g++)
        for (int p = 0; p < (1 << s); p++) begin
          qb.push_back(enc(s, g * (2 << s) + p, g * (2 << s) + p + (1 << s), p * (8 >> s), (kk % 8 == 7) ? 1 : 0));
          kk++;
        end
  endtask
  int a_held = 0;
  logic a_stalled = 1'b0;
  always @(negedge clk) begin
    int cur;
    cur = enc(int'(a_stage), int'(a_aa), int'(a_ab), int'(a_tw), int'(a_last));
    if (a_stalled) begin
      chk("a_hold_vld", int'(a_vld), 1);
      chk("a_hold_cmd", cur, a_held);
    end
    if (a_vld && a_rdy) begin
      if (qa.size() == 0) chk("a_unexpected_cmd", cur, -1);
      else chk("a_cmd", cur, qa.pop_front());
    end
    a_stalled <= a_vld && !a_rdy;
    a_held <= cur;
  end
  always @(negedge clk) begin
    int cur;
    cur = enc(int'(b_stage), int'(b_aa), int'(b_ab), int'(b_tw), int'(b_last));
    if (b_vld && b_rdy) begin
      if (qb.size() == 0) chk("b_unexpected_cmd", cur, -1);
      else chk("b_cmd", cur, qb.pop_front());
    end
  end
  always @(negedge clk) begin
    int cur;
    cur = enc(int'(c_stage), int'(c_aa), int'(c_ab), int'(c_tw), int'(c_last));
    if (c_vld && c_rdy) begin
      if (qc.size() == 0) chk("c_unexpected_cmd", cur, -1);
      else chk("c_cmd", cur, qc.pop_front());
    end
  end
  task automatic pulse_a();
    @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
  endtask
  task automatic a_watch(input bit stall, input bit poke, output int bcyc, output int nstall, output int ndone);
    int gap;
    gap = 0;
    bcyc = 0;
    nstall = 0;
    ndone = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (t == 0) chk("a_start_latency", int'({a_busy, a_vld}), 3);
      if (a_done) ndone++;
      if (!a_busy) break;
      bcyc++;
      if (a_vld && !a_rdy) nstall++;
      if (!a_vld) gap++;
      else begin
        if (gap != 0) chk("a_drain_gap", gap, 2);
        gap = 0;
      end
      @(posedge clk);
      #1;
      if (stall) a_rdy = ~a_rdy;
      if (poke) a_start = (a_stage == 2'd1 && a_vld) || (a_stage == 2'd0 && !a_vld);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_reset_outputs", int'({a_busy, a_done, a_vld, a_last, a_stage, a_aa, a_ab, a_tw}), 0);
    chk("b_reset_outputs", int'({b_busy, b_done, b_vld, b_last, b_stage, b_aa, b_ab, b_tw}), 0);
    chk("c_reset_outputs", int'({c_busy, c_done, c_vld, c_last, c_stage, c_aa, c_ab, c_tw}), 0);
    @(posedge clk);
    #1;
    a_rstn = 1'b1;
    b_rstn = 1'b1;
    c_rstn = 1'b1;
    fork
      begin
        int bc, ns, nd, found;
        push8(0);
        pulse_a();
        a_watch(1'b0, 1'b0, bc, ns, nd);
        chk("a_busy_cycles", bc, 18);
        chk("a_done_count", nd, 1);
        @(negedge clk);
        chk("a_done_width", int'(a_done), 0);
        chk("a_queue_run1", qa.size(), 0);
        push8(0);
        pulse_a();
        a_rdy = 1'b0;
        a_watch(1'b1, 1'b0, bc, ns, nd);
        a_rdy = 1'b1;
        chk("a_stall_busy_cycles", bc, 30);
        chk("a_stall_count", ns, 12);
        chk("a_stall_done_count", nd, 1);
        chk("a_queue_stall", qa.size(), 0);
        push8(0);
        pulse_a();
        a_watch(1'b0, 1'b1, bc, ns, nd);
        chk("a_poke_busy_cycles", bc, 18);
        chk("a_poke_done_count", nd, 1);
        chk("a_queue_poke", qa.size(), 0);
        push8(0);
        a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        a_watch(1'b0, 1'b0, bc, ns, nd);
        chk("a_redone_busy_cycles", bc, 18);
        chk("a_redone_done_count", nd, 1);
        chk("a_queue_redone", qa.size(), 0);
        push8(0);
        pulse_a();
        found = 0;
        for (int t = 0; t < 100; t++) begin
          @(posedge clk);
          #1;
          if (a_stage == 2'd1 && a_vld && a_aa == 3'd4) begin
            found = 1;
            break;
          end
        end
        chk("a_reach_s1_k2", found, 1);
        a_rstn = 1'b0;
        @(posedge clk);
        #1 a_rstn = 1'b1;
        qa.delete();
        @(negedge clk);
        chk("a_mid_reset_outputs", int'({a_busy, a_done, a_vld, a_last, a_stage, a_aa, a_ab, a_tw}), 0);
        nd = 0;
        repeat (5) begin
          @(negedge clk);
          if (a_done || a_busy) nd++;
        end
        chk("a_quiet_after_reset", nd, 0);
        push8(0);
        pulse_a();
        a_watch(1'b0, 1'b0, bc, ns, nd);
        chk("a_restart_busy_cycles", bc, 18);
        chk("a_restart_done_count", nd, 1);
        chk("a_queue_restart", qa.size(), 0);
      end
      begin
        int n, lc;
        n = 0;
        lc = 0;
        pushb();
        @(posedge clk);
        #1 b_start = 1'b1;
        @(posedge clk);
        #1 b_start = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 100 && b_vld; t++) begin
          n++;
          if (b_last) lc++;
          @(negedge clk);
        end
        chk("b_run_length", n, 32);
        chk("b_last_count", lc, 4);
        chk("b_done_after_last", int'(b_done), 1);
        chk("b_busy_at_done", int'(b_busy), 0);
        @(negedge clk);
        chk("b_done_width", int'(b_done), 0);
        chk("b_queue", qb.size(), 0);
      end
      begin
        int nd;
        int d[3];
        nd = 0;
        d = '{0, 0, 0};
        push8(1);
        push8(1);
        push8(1);
        for (int t = 0; t < 200 && nd < 3; t++) begin
          @(negedge clk);
          if (c_done) begin
            d[nd] = cyc;
            nd++;
            if (nd == 2) begin
              @(posedge clk);
              #1 c_start = 1'b0;
            end
          end
        end
        chk("c_done_count", nd, 3);
        chk("c_period_1", d[1] - d[0], 16);
        chk("c_period_2", d[2] - d[1], 16);
        @(negedge clk);
        chk("c_idle_after", int'(c_busy), 0);
        chk("c_queue", qc.size(), 0);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_stage_seq.md
# fft_stage_seq

Sequencer for the in-place radix-2 DIT FFT engine. After a `start` pulse it walks all log2(N) stages and, within each stage, every butterfly. For each butterfly it issues the operand pair addresses and the twiddle index to the butterfly datapath over a valid/ready handshake. Between stages it waits out the butterfly pipeline latency, so read-after-write hazards on the shared in-place sample memory cannot occur. It sits between the top-level FFT control and the stage counter/butterfly/memory datapath.

## Interface
- `N`, 16: FFT points; power of two, ≥4. `L = $clog2(N)` stages; `N/2` butterflies per stage.
- `BF_LAT`, 3: butterfly read-to-writeback latency in cycles; ≥0.
- `clk` in 1: single clock; all logic on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `start` in 1: request one full transform; sampled only in IDLE.
- `busy` out 1: transform in progress.
- `done` out 1: one-cycle pulse when the transform completes.
- `stage` out `$clog2(L)`: current stage s, 0..L-1.
- `bf_vld` out 1: butterfly command valid.
- `bf_rdy` in 1: datapath accepts the command.
- `addr_a` out `$clog2(N)`: upper-leg sample address.
- `addr_b` out `$clog2(N)`: lower-leg sample address.
- `tw_addr` out `$clog2(N)-1`: twiddle ROM index into the N/2-entry table.
- `bf_last` out 1: current command is the last butterfly of its stage.

## Operation
- Samples are already bit-reversed in memory; output ends in natural order.
- FSM states:
  - **IDLE**: `busy`=0, `bf_vld`=0. On `start`=1 go to RUN with s=0, k=0.
  - **RUN**: `bf_vld`=1. A command is accepted only when `bf_vld && bf_rdy`. On acceptance, k increments. On acceptance with k=N/2-1, k wraps to 0 and the FSM goes to DRAIN. If `BF_LAT`=0 it skips DRAIN and applies the DRAIN exit directly.
  - **DRAIN**: `bf_vld`=0. The drain counter counts `BF_LAT` cycles. On exit:
    - if s≠L-1: s increments and the FSM returns to RUN;
    - if s=L-1: the FSM goes to IDLE and `done` pulses.
- Address generation per (s, k), with span=2^s:
  - pos = k & (span-1)
  - grp = k >> s
  - `addr_a` = (grp << (s+1)) | pos
  - `addr_b` = `addr_a` + span
  - `tw_addr` = pos << (L-1-s)
- All arithmetic is unsigned and truncated to the port widths. `addr_b` never overflows.
- `bf_last` = (k == N/2-1) while `bf_vld`=1; otherwise 0.
- While `bf_rdy`=0 the command is held stable: `stage`, `addr_a`, `addr_b`, `tw_addr` and `bf_last` do not change, and `bf_vld` stays 1.
- `start` while `busy`=1 is ignored; it is neither queued nor causes a restart.
- Reset values (`rstn`=0 at any time, including mid-transform): state=IDLE, s=0, k=0, drain count=0.
  - All outputs are 0: `busy`, `done`, `bf_vld`, `bf_last`, `stage`, `addr_a`, `addr_b`, `tw_addr`.
  - The transform is abandoned and no `done` is produced.

## Timing
- All outputs are registered.
- `start` high at edge T: `busy`=1 and `bf_vld`=1 (s=0, k=0) from cycle T+1.
- No-stall throughput is one butterfly per cycle.
- Last butterfly of a stage accepted at cycle E:
  - `bf_vld`=0 for cycles E+1..E+`BF_LAT`;
  - the next stage's k=0 command is presented at E+`BF_LAT`+1.
- Final stage: `done`=1 and `busy`=0 at cycle E+`BF_LAT`+1. `done` lasts exactly one cycle.
- `start` high in the `done` cycle is accepted; the FSM is already in IDLE.
- No-stall busy duration is L·(N/2 + `BF_LAT`) cycles. Each `bf_rdy`=0 cycle during RUN adds one cycle.

## Test plan
- N=8, `BF_LAT`=2, `bf_rdy`=1, pulse `start`. Expected (a,b,tw) sequence:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0);
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2);
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - Also check: 2-cycle `bf_vld` gap between stages, `busy` high for 18 cycles, `done` one cycle after the last drain.
- Same configuration with `bf_rdy` low on every other cycle: identical command sequence, outputs stable while stalled, `busy` high for exactly 18 + number of stall cycles.
- `BF_LAT`=0, N=16: 32 consecutive commands with no gaps across all 4 stages; `bf_last` high on k=7 of each stage; `done` the cycle after the 32nd acceptance.
- `start` pulsed during stage 1 and again during DRAIN: no effect on the sequence, exactly one `done`. Then `start` in the `done` cycle: a new transform begins the next cycle at s=0, k=0.
- `rstn`=0 for one cycle mid-stage 1 (k=2): the next cycle shows all outputs 0, IDLE, no `done`. A following `start` restarts cleanly at s=0, k=0.
- `start` held high continuously, N=8, `BF_LAT`=1: back-to-back transforms. `done` pulses every 16 cycles, and each transform restarts at s=0, k=0.
